// File: rtl/router_rr_sched_if.sv
// router_rr_sched_if
// Bundle between a router's round-robin scheduler and its four bus
// interfaces (input FIFO heads and output FIFO status).
//   pndng_i    : input terminal i has a packet at its FIFO head
//   Data_out_i : head packet of each input terminal (destination byte on top)
//   full_o     : output FIFO j is full
//   Trn        : granted terminal index (selects the interface that pops)
//   push_i     : one-cycle push of Data_in_i into the destination output FIFO
//   pop_i      : one-cycle pop of input terminal Trn
//   Data_in_i  : packet currently being transferred
//   drop_o     : one-cycle pulse when an invalid-destination packet is discarded
//   busy       : scheduler is in the middle of a transfer
// modport master : scheduler side; modport slave : router/FIFO side.
interface router_rr_sched_if #(
  parameter int pckg_sz = 40
);
  logic [3:0]         pndng_i;
  logic [pckg_sz-1:0] Data_out_i [4];
  logic [3:0]         full_o;
  logic [1:0]         Trn;
  logic               push_i;
  logic               pop_i;
  logic [pckg_sz-1:0] Data_in_i;
  logic               drop_o;
  logic               busy;

  modport master (
    input  pndng_i, Data_out_i, full_o,
    output Trn, push_i, pop_i, Data_in_i, drop_o, busy
  );

  modport slave (
    output pndng_i, Data_out_i, full_o,
    input  Trn, push_i, pop_i, Data_in_i, drop_o, busy
  );
endinterface

// File: rtl/router_rr_sched.sv
// router_rr_sched
// Round-robin scheduler sharing a router's single internal transfer path
// among its four input terminals. One pending input is granted at a time,
// its head packet is latched, pushed into the output FIFO named by the
// destination byte and then popped from the source input. Packets whose
// destination byte is above 3 are popped without a push and flagged on drop_o.
//
// Ports:
//   clk : clock, all state changes on the rising edge
//   rst : synchronous active-high reset
//   bus : router_rr_sched_if.master (pndng_i, Data_out_i, full_o in;
//         Trn, push_i, pop_i, Data_in_i, drop_o, busy out)
//
// Optional feature macro: ROUTER_SCHED_FULL_CHK_EN
//   defined   : CHK waits while the destination output FIFO reports full
//   undefined : full_o is ignored; CHK always lasts exactly one cycle
module router_rr_sched #(
  parameter int pckg_sz = 40,
  parameter int N_TERM  = 4
) (
  input  logic                clk,
  input  logic                rst,
  router_rr_sched_if.master   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CHK  = 2'd1,
    PUSH = 2'd2,
    POP  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [1:0]         trn_q, trn_d;
  logic [pckg_sz-1:0] data_q, data_d;
  logic [7:0]         dest_q, dest_d;
  logic               drop_flag_q, drop_flag_d;
  logic               push_q, pop_q, drop_q, busy_q;

  logic               found_s;
  logic [1:0]         sel_s;
  logic               stall_s;

`ifdef ROUTER_SCHED_FULL_CHK_EN
  // Only the low two bits matter here: dest above 3 is handled before stall.
  assign stall_s = bus.full_o[dest_q[1:0]];
`else
  logic unused_full_s;
  assign unused_full_s = ^bus.full_o;
  assign stall_s       = 1'b0;
`endif

  // Rotating priority search: first pending terminal at or after ptr wins.
  always_comb begin
    found_s = 1'b0;
    sel_s   = ptr_q;
    for (int k = 0; k < N_TERM; k++) begin
      if (!found_s && bus.pndng_i[ptr_q + 2'(k)]) begin
        found_s = 1'b1;
        sel_s   = ptr_q + 2'(k);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Next-state and datapath latch decisions.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    trn_d       = trn_q;
    data_d      = data_q;
    dest_d      = dest_q;
    drop_flag_d = drop_flag_q;
    case (state_q)
      IDLE: begin
        if (found_s) begin
          trn_d   = sel_s;
          data_d  = bus.Data_out_i[sel_s];
          dest_d  = bus.Data_out_i[sel_s][pckg_sz-1 -: 8];
          state_d = CHK;
        end else begin
          state_d = IDLE;
        end
      end
      CHK: begin
        if (dest_q > 8'd3) begin
          drop_flag_d = 1'b1;
          state_d     = POP;
        end else if (stall_s) begin
          state_d = CHK;
        end else begin
          state_d = PUSH;
        end
      end
      PUSH: begin
        state_d = POP;
      end
      POP: begin
        // Next search starts just past the terminal that was served.
        ptr_d       = trn_q + 2'd1;
        drop_flag_d = 1'b0;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and output registers; strobes are decoded from next state
  // so they are flops that line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= 2'd0;
      trn_q       <= 2'd0;
      data_q      <= '0;
      dest_q      <= 8'd0;
      drop_flag_q <= 1'b0;
      push_q      <= 1'b0;
      pop_q       <= 1'b0;
      drop_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      trn_q       <= trn_d;
      data_q      <= data_d;
      dest_q      <= dest_d;
      drop_flag_q <= drop_flag_d;
      push_q      <= (state_d == PUSH);
      pop_q       <= (state_d == POP);
      drop_q      <= (state_d == POP) && drop_flag_d;
      busy_q      <= (state_d != IDLE);
    end
  end

  assign bus.Trn       = trn_q;
  assign bus.Data_in_i = data_q;
  assign bus.push_i    = push_q;
  assign bus.pop_i     = pop_q;
  assign bus.drop_o    = drop_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_router_rr_sched.sv
`timescale 1ns/1ps
module tb_router_rr_sched;
  localparam int PW = 40;
`ifdef ROUTER_SCHED_FULL_CHK_EN
  localparam bit FULL_EN = 1'b1;
`else
  localparam bit FULL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  router_rr_sched_if #(.pckg_sz(PW)) bus ();
  router_rr_sched #(.pckg_sz(PW), .N_TERM(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct { int cyc; logic [1:0] trn; logic [PW-1:0] data; logic drop; } exp_t;
  typedef struct { int term; logic [PW-1:0] data; } load_t;

  // Environment: per-terminal input FIFOs and requests to fill them.
  logic [PW-1:0] inq [4][$];
  load_t         load_q [$];
  bit            rand_en = 1'b0;
  bit            full_rand_en = 1'b0;
  logic [3:0]    full_force = 4'd0;

  // Scoreboard queues filled by the reference model.
  exp_t push_exp [$];
  exp_t pop_exp  [$];

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int grant_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  function automatic logic [PW-1:0] gen_pkt();
    logic [7:0] d;
    if ($urandom_range(0, 7) == 0) d = 8'($urandom_range(4, 255));
    else d = 8'($urandom_range(0, 3));
    return {d, 32'($urandom)};
  endfunction

  function automatic bit all_empty();
    for (int t = 0; t < 4; t++) if (inq[t].size() > 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic load(input int term, input logic [PW-1:0] data);
    load_t l;
    l.term = term;
    l.data = data;
    load_q.push_back(l);
  endtask

  // Environment process: pops on pop_i, applies loads, drives FIFO status.
  initial begin
    logic [PW-1:0] tmp;
    load_t ld;
    forever begin
      @(negedge clk);
      if (bus.pop_i && inq[bus.Trn].size() > 0) tmp = inq[bus.Trn].pop_front();
      while (load_q.size() > 0) begin
        ld = load_q.pop_front();
        inq[ld.term].push_back(ld.data);
      end
      if (rand_en)
        for (int t = 0; t < 4; t++)
          if ($urandom_range(0, 9) == 0 && inq[t].size() < 4) inq[t].push_back(gen_pkt());
      if (full_rand_en) bus.full_o = 4'($urandom) & 4'($urandom);
      else bus.full_o = full_force;
      for (int t = 0; t < 4; t++) begin
        bus.pndng_i[t]    = (inq[t].size() > 0);
        bus.Data_out_i[t] = (inq[t].size() > 0) ? inq[t][0] : '0;
      end
    end
  end

  // Reference model: one transfer at a time; the grant goes to the first pending
  // terminal in rotating order from the pointer; a valid packet is pushed the
  // cycle after CHK resolves and popped one cycle later, an invalid one is
  // popped straight away; the next grant needs one IDLE cycle after the pop.
  initial begin
    logic [1:0]    mptr = 2'd0;
    bit            mact = 1'b0;
    logic [1:0]    mtrn = 2'd0;
    logic [PW-1:0] mdata = '0;
    logic [7:0]    dest;
    int            next_ok = 0;
    int            t;
    exp_t          e;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        mact = 1'b0;
        mptr = 2'd0;
        next_ok = cyc + 1;
      end else if (mact) begin
        dest = mdata[PW-1 -: 8];
        e.trn = mtrn;
        e.data = mdata;
        if (dest > 8'd3) begin
          e.cyc = cyc; e.drop = 1'b1; pop_exp.push_back(e);
          next_ok = cyc + 2; mptr = mtrn + 2'd1; mact = 1'b0;
        end else if (FULL_EN && bus.full_o[dest[1:0]]) begin
          mact = 1'b1;
        end else begin
          e.drop = 1'b0;
          e.cyc = cyc;     push_exp.push_back(e);
          e.cyc = cyc + 1; pop_exp.push_back(e);
          next_ok = cyc + 3; mptr = mtrn + 2'd1; mact = 1'b0;
        end
      end else if (cyc >= next_ok) begin
        for (int k = 0; k < 4; k++) begin
          t = (int'(mptr) + k) % 4;
          if (!mact && bus.pndng_i[t]) begin
            mact = 1'b1;
            mtrn = 2'(t);
            mdata = bus.Data_out_i[t];
            grant_cnt++;
          end
        end
      end
    end
  end

  // Monitor: compares DUT strobes and payload against the scoreboard every cycle.
  initial begin
    exp_t me;
    bit ep, eo;
    forever begin
      @(negedge clk);
      ep = (push_exp.size() > 0) && (push_exp[0].cyc == cyc);
      check("push_strobe", 64'(bus.push_i), 64'(ep));
      if (ep) begin
        me = push_exp.pop_front();
        if (bus.push_i) begin
          check("push_trn", 64'(bus.Trn), 64'(me.trn));
          check("push_data", 64'(bus.Data_in_i), 64'(me.data));
        end
      end
      eo = (pop_exp.size() > 0) && (pop_exp[0].cyc == cyc);
      check("pop_strobe", 64'(bus.pop_i), 64'(eo));
      if (eo) begin
        me = pop_exp.pop_front();
        check("drop_strobe", 64'(bus.drop_o), 64'(me.drop));
        if (bus.pop_i) check("pop_trn", 64'(bus.Trn), 64'(me.trn));
      end else begin
        check("drop_strobe", 64'(bus.drop_o), 64'd0);
      end
      while (push_exp.size() > 0 && push_exp[0].cyc < cyc) begin
        check("push_late", 64'(cyc), 64'(push_exp[0].cyc));
        me = push_exp.pop_front();
      end
      while (pop_exp.size() > 0 && pop_exp[0].cyc < cyc) begin
        check("pop_late", 64'(cyc), 64'(pop_exp[0].cyc));
        me = pop_exp.pop_front();
      end
    end
  end

  task automatic wait_drain(input int budget);
    int n = 0;
    repeat (2) @(negedge clk);
    while (n < budget && !(all_empty() && load_q.size() == 0 && push_exp.size() == 0 &&
                           pop_exp.size() == 0 && !bus.busy)) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", (n >= budget) ? 64'd1 : 64'd0, 64'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, 64'(bus.busy), 64'd0);
    check({tag, "_push"}, 64'(bus.push_i), 64'd0);
    check({tag, "_pop"}, 64'(bus.pop_i), 64'd0);
    check({tag, "_drop"}, 64'(bus.drop_o), 64'd0);
    check({tag, "_trn"}, 64'(bus.Trn), 64'd0);
    check({tag, "_data"}, 64'(bus.Data_in_i), 64'd0);
  endtask

  initial begin
    int g0;
    int n;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;

    // Idle with nothing pending.
    repeat (10) begin
      @(negedge clk);
      check("idle_busy", 64'(bus.busy), 64'd0);
      check("idle_push", 64'(bus.push_i), 64'd0);
      check("idle_pop", 64'(bus.pop_i), 64'd0);
      check("idle_trn", 64'(bus.Trn), 64'd0);
    end

    // Single packet on terminal 2; Trn/Data_in_i must hold afterwards.
    load(2, 40'h01_0000_ABCD);
    wait_drain(100);
    check("hold_trn", 64'(bus.Trn), 64'd2);
    check("hold_data", 64'(bus.Data_in_i), 64'h01_0000_ABCD);

    // All four pending and held: rotating grants.
    for (int r = 0; r < 2; r++)
      for (int t = 0; t < 4; t++) load(t, {8'(t), 32'(r * 16 + t + 32'h100)});
    wait_drain(200);

    // Destination 3 while output FIFO 3 reports full.
    full_force = 4'b1000;
    load(0, 40'h03_1234_5678);
    repeat (7) @(negedge clk);
    full_force = 4'b0000;
    wait_drain(100);

    // Invalid destination on terminal 1, then all pending to exercise the pointer.
    load(1, 40'h07_DEAD_BEEF);
    wait_drain(100);
    for (int t = 0; t < 4; t++) load(t, {8'(3 - t), 32'(t + 32'h200)});
    wait_drain(200);

    // Reset while in CHK: transfer aborted, same terminal granted again.
    g0 = grant_cnt;
    load(3, 40'h00_CAFE_0003);
    n = 0;
    while (grant_cnt == g0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("grant_seen", (grant_cnt != g0) ? 64'd1 : 64'd0, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check_outputs_zero("midreset");
    check("midreset_head_kept", 64'(inq[3].size()), 64'd1);
    rst = 1'b0;
    wait_drain(100);
    check("regrant_trn", 64'(bus.Trn), 64'd3);

    // Randomized traffic with random full status.
    rand_en = 1'b1;
    full_rand_en = 1'b1;
    repeat (3000) @(negedge clk);
    rand_en = 1'b0;
    full_rand_en = 1'b0;
    wait_drain(2000);
    check("push_exp_left", 64'(push_exp.size()), 64'd0);
    check("pop_exp_left", 64'(pop_exp.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
